// File: rtl/hangman_rx_ctrl.sv
// Receive-side controller for the hangman player station: arms the UART path,
// turns each received byte into a fresh uppercase guess and reports errors.
module hangman_rx_ctrl #(
  parameter int ERR_HOLD = 200,
  parameter int TIMEOUT  = 30000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        enable,
  input  logic        new_game,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic        rec_ready,
  output logic [7:0]  guess,
  output logic        guess_valid,
  input  logic        guess_ack,
  output logic        err_LED,
  output logic        dup_guess,
  output logic        timeout,
  output logic [25:0] used_mask
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CHECK,
    S_PRESENT,
    S_ERR
  } state_t;

  state_t      r_state;
  logic        r_rec_ready;
  logic [7:0]  r_guess;
  logic        r_guess_valid;
  logic        r_err_led;
  logic        r_dup;
  logic        r_timeout;
  logic [25:0] r_used_mask;
  logic [TW-1:0] r_timer;
  logic [HW-1:0] r_hold;
  logic [7:0]  r_byte;

  logic        w_is_lower;
  logic        w_is_upper;
  logic        w_is_letter;
  logic [7:0]  w_letter;
  logic [4:0]  w_idx;
  logic [25:0] w_letter_bit;
  logic        w_is_dup;

  assign w_is_lower  = (r_byte >= 8'h61) && (r_byte <= 8'h7A);
  assign w_is_upper  = (r_byte >= 8'h41) && (r_byte <= 8'h5A);
  assign w_is_letter = w_is_lower || w_is_upper;
  assign w_letter    = w_is_lower ? (r_byte - 8'h20) : r_byte;
  // 'A'..'Z' have low five bits 1..26, so the mask index is one less.
  assign w_idx       = w_letter[4:0] - 5'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 26; gi++) begin : g_letter_bit
      assign w_letter_bit[gi] = (w_idx == 5'(gi));
    end
  endgenerate

  assign w_is_dup = |(r_used_mask & w_letter_bit);

  always_ff @(posedge clk) begin
    if (Rst || new_game) begin
      r_state       <= S_IDLE;
      r_rec_ready   <= 1'b0;
      r_guess       <= 8'h00;
      r_guess_valid <= 1'b0;
      r_err_led     <= 1'b0;
      r_dup         <= 1'b0;
      r_timeout     <= 1'b0;
      r_used_mask   <= '0;
      r_timer       <= '0;
      r_hold        <= '0;
      r_byte        <= 8'h00;
    end else begin
      r_dup     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rec_ready <= 1'b0;
          if (enable) begin
            r_state     <= S_ARM;
            r_rec_ready <= 1'b1;
            r_timer     <= '0;
          end
        end
        S_ARM: begin
          if (!enable) begin
            r_state     <= S_IDLE;
            r_rec_ready <= 1'b0;
          end else if (rx_err) begin
            r_state     <= S_ERR;
            r_rec_ready <= 1'b0;
            r_err_led   <= 1'b1;
            r_hold      <= '0;
          end else if (rx_valid) begin
            r_state     <= S_CHECK;
            r_byte      <= rx_byte;
            r_rec_ready <= 1'b0;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_timer   <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CHECK: begin
          if (!w_is_letter) begin
            r_state   <= S_ERR;
            r_err_led <= 1'b1;
            r_hold    <= '0;
          end else if (w_is_dup) begin
            r_state     <= S_ARM;
            r_dup       <= 1'b1;
            r_rec_ready <= 1'b1;
            r_timer     <= '0;
          end else begin
            r_state       <= S_PRESENT;
            r_guess       <= w_letter;
            r_guess_valid <= 1'b1;
            r_used_mask   <= r_used_mask | w_letter_bit;
          end
        end
        S_PRESENT: begin
          // Hold the guess until the game logic takes it, even if enable drops.
          if (r_guess_valid && guess_ack) begin
            r_guess_valid <= 1'b0;
            if (enable) begin
              r_state     <= S_ARM;
              r_rec_ready <= 1'b1;
              r_timer     <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          if (r_hold == HW'(ERR_HOLD - 1)) begin
            r_err_led <= 1'b0;
            if (enable) begin
              r_state     <= S_ARM;
              r_rec_ready <= 1'b1;
              r_timer     <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rec_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rec_ready   = r_rec_ready;
  assign guess       = r_guess;
  assign guess_valid = r_guess_valid;
  assign err_LED     = r_err_led;
  assign dup_guess   = r_dup;
  assign timeout     = r_timeout;
  assign used_mask   = r_used_mask;

endmodule

// File: doc/hangman_rx_ctrl.md
Name: hangman_rx_ctrl

Overview:
- Sequences the UART receiver + guess buffer path for the hangman player station.
- Arms the receiver through rec_ready and takes each completed byte from the buffer.
- Normalises the byte to an uppercase ASCII letter, rejects non-letters and repeated letters, and hands accepted guesses to the game logic over a valid/ack handshake.
- Drives the error LED on receive or format errors and flags receive timeouts.

Parameters:
- ERR_HOLD, 200, cycles err_LED stays high per error event (2 s at the 100 Hz system clock).
- TIMEOUT, 30000, cycles in ARM without a byte before a timeout pulse; timer width is $clog2(TIMEOUT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  reset; synchronous, active-high.
- enable  input  1  game active; level-sensitive.
- new_game  input  1  one-cycle pulse; soft reset of guess state.
- rx_byte  input  8  byte from the receive buffer; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe: byte complete.
- rx_err  input  1  one-cycle strobe: receiver framing error.
- rec_ready  output  1  enables the receiver/buffer to capture a byte.
- guess  output  8  accepted guess, uppercase ASCII 0x41-0x5A.
- guess_valid  output  1  guess available to game logic.
- guess_ack  input  1  game logic consumed guess.
- err_LED  output  1  error indicator.
- dup_guess  output  1  one-cycle pulse: letter already used.
- timeout  output  1  one-cycle pulse: no byte within TIMEOUT.
- used_mask  output  26  bit i set means letter 'A'+i already guessed.

Behaviour:
- All outputs are registered.
- Reset (Rst=1 at a clk edge):
  - state=IDLE.
  - rec_ready, guess_valid, err_LED, dup_guess, timeout = 0.
  - guess=8'h00, used_mask=0, timer=0, hold counter=0.
- new_game=1 behaves identically to Rst and has priority over every other event.
- States:
  - IDLE:
    - rec_ready=0.
    - enable=1 -> ARM; rec_ready=1 from the next cycle.
  - ARM:
    - rec_ready=1; timer increments each cycle.
    - enable=0 -> IDLE.
    - rx_err=1 -> ERR. rx_err has priority over rx_valid in the same cycle.
    - rx_valid=1 -> CHECK; rx_byte is latched and rec_ready drops next cycle.
    - Timer reaches TIMEOUT-1 -> timeout=1 for one cycle, timer restarts at 0, state stays ARM.
    - Timer is cleared on every entry to ARM.
  - CHECK (exactly 1 cycle, rec_ready=0):
    - Byte 0x61-0x7A -> letter = byte - 0x20.
    - Byte 0x41-0x5A -> letter = byte.
    - Any other byte -> ERR.
    - Letter bit already set in used_mask -> dup_guess=1 for one cycle -> ARM. guess, guess_valid and used_mask are unchanged.
    - Otherwise guess<=letter, used_mask[letter-0x41]<=1, guess_valid<=1 -> PRESENT.
  - PRESENT:
    - rec_ready=0; guess and guess_valid are held stable.
    - guess_ack is sampled only while guess_valid=1; ack outside PRESENT is ignored.
    - On ack: guess_valid=0 next cycle; next state is ARM if enable=1, else IDLE.
    - guess keeps its last value after ack.
    - enable falling in PRESENT does not drop guess_valid; the controller waits for ack.
  - ERR:
    - err_LED=1 and rec_ready=0 for exactly ERR_HOLD cycles, counted from the first ERR cycle.
    - Then err_LED=0 and next state is ARM if enable=1, else IDLE.
    - rx_valid and rx_err are ignored in ERR.
- Latency:
  - rx_valid at edge N -> CHECK at N+1 -> guess_valid=1 visible after edge N+2.
  - Earliest rearm after ack: rec_ready=1 one cycle after the ack edge.
- Byte handling:
  - Bytes arriving while rec_ready=0 are ignored; the receiver must not be armed then.
  - used_mask saturates; after all 26 letters every letter yields dup_guess.

Test Plan:
1. Rst=1 for 2 cycles, enable=1 -> all outputs 0 during reset; rec_ready=1 one cycle after Rst falls (IDLE->ARM).
2. rx_byte=0x61, rx_valid pulse at edge N -> guess=0x41 and guess_valid=1 after N+2, used_mask=26'h0000001, rec_ready=0. guess_ack=1 -> guess_valid=0 and rec_ready=1 next cycle.
3. Then rx_byte=0x41 -> dup_guess high exactly 1 cycle, guess_valid stays 0, used_mask unchanged, rec_ready returns to 1.
4. rx_byte=0x0A (newline) -> err_LED=1 for exactly ERR_HOLD=200 cycles, rec_ready=0 throughout, then rec_ready=1. Separately, rx_err and rx_valid in the same cycle (byte 0x42) -> ERR path taken, used_mask bit1 stays 0.
5. ARM with no byte -> timeout pulse exactly TIMEOUT cycles after ARM entry, then a second pulse TIMEOUT cycles later; state stays ARM.
6. new_game pulse while in PRESENT with guess 0x5A -> next cycle guess_valid=0, guess=0x00, used_mask=0, state IDLE, then ARM on enable=1.
